// File: rtl/huffman_tree_build.sv
// huffman_tree_build
//   Builds an 8-symbol Huffman tree from 8 symbol frequencies using a
//   sequential min-scan: each merge scans the 15-entry pool twice (one entry
//   per cycle) for the two lightest active entries, then merges them.
// Ports
//   CLK, RST                  clock (rising edge), synchronous active-high reset
//   start                     one-cycle build request, accepted only in IDLE
//   freq_0..freq_7            symbol frequencies, captured in the LOAD cycle
//   busy                      high from LOAD through DONE
//   done                      one-cycle pulse; tree outputs valid from here on
//   sat                       a merged weight clipped to 8'hFF during the last build
//   info_node_1..info_node_7  internal node k: {parent[3:0], branch, weight}
//   leaf_info_0..leaf_info_7  leaf s: {parent node index, branch}
module huffman_tree_build #(
  parameter int unsigned WW   = 8,
  parameter int unsigned NSYM = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [WW-1:0]   freq_0,
  input  logic [WW-1:0]   freq_1,
  input  logic [WW-1:0]   freq_2,
  input  logic [WW-1:0]   freq_3,
  input  logic [WW-1:0]   freq_4,
  input  logic [WW-1:0]   freq_5,
  input  logic [WW-1:0]   freq_6,
  input  logic [WW-1:0]   freq_7,
  output logic            busy,
  output logic            done,
  output logic            sat,
  output logic [WW+4:0]   info_node_1,
  output logic [WW+4:0]   info_node_2,
  output logic [WW+4:0]   info_node_3,
  output logic [WW+4:0]   info_node_4,
  output logic [WW+4:0]   info_node_5,
  output logic [WW+4:0]   info_node_6,
  output logic [WW+4:0]   info_node_7,
  output logic [4:0]      leaf_info_0,
  output logic [4:0]      leaf_info_1,
  output logic [4:0]      leaf_info_2,
  output logic [4:0]      leaf_info_3,
  output logic [4:0]      leaf_info_4,
  output logic [4:0]      leaf_info_5,
  output logic [4:0]      leaf_info_6,
  output logic [4:0]      leaf_info_7
);

  localparam int unsigned NPOOL = 2 * NSYM - 1;
  localparam int unsigned NNODE = NSYM - 1;
  localparam int unsigned NREC  = 4 + 1 + WW;
  localparam logic [3:0]  LAST_IDX  = 4'(NPOOL - 1);
  localparam logic [3:0]  NODE_BASE = 4'(NSYM - 1);
  localparam logic [2:0]  LAST_K    = 3'(NNODE);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SCAN1, S_SCAN2, S_MERGE, S_DONE
  } state_t;

  state_t          r_state;
  logic [3:0]      r_idx;
  logic [3:0]      r_min1;
  logic [3:0]      r_min2;
  logic [2:0]      r_k;
  logic            r_found;
  logic [WW-1:0]   r_best;
  logic            r_busy;
  logic            r_done;
  logic            r_sat;

  // Working pool: entries 0..7 leaves, 8..14 internal nodes 1..7
  logic [WW-1:0]   r_w   [NPOOL];
  logic            r_act [NPOOL];
  logic [3:0]      r_par [NPOOL];
  logic            r_br  [NPOOL];

  // Published tree, updated only in DONE
  logic [NREC-1:0] r_node [NNODE];
  logic [4:0]      r_leaf [NSYM];

  logic [WW-1:0]   w_freq [NSYM];
  logic            w_first;
  logic            w_take1;
  logic            w_take2;
  logic [WW:0]     w_sum;
  logic [WW-1:0]   w_merged;
  logic [3:0]      w_new;

  assign w_freq[0] = freq_0;
  assign w_freq[1] = freq_1;
  assign w_freq[2] = freq_2;
  assign w_freq[3] = freq_3;
  assign w_freq[4] = freq_4;
  assign w_freq[5] = freq_5;
  assign w_freq[6] = freq_6;
  assign w_freq[7] = freq_7;

  // Strict less-than in ascending index order: lowest index wins ties.
  // Index 0 restarts the search regardless of the previous scan's result.
  assign w_first = (r_idx == 4'd0);
  assign w_take1 = r_act[r_idx] && (w_first || !r_found || (r_w[r_idx] < r_best));
  assign w_take2 = w_take1 && (r_idx != r_min1);

  // Merge arithmetic with saturation to all-ones
  assign w_sum    = {1'b0, r_w[r_min1]} + {1'b0, r_w[r_min2]};
  assign w_merged = w_sum[WW] ? {WW{1'b1}} : w_sum[WW-1:0];
  assign w_new    = NODE_BASE + {1'b0, r_k};

  // Build FSM with pool and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_min1  <= '0;
      r_min2  <= '0;
      r_k     <= '0;
      r_found <= 1'b0;
      r_best  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sat   <= 1'b0;
      for (int unsigned i = 0; i < NPOOL; i++) begin
        r_w[i]   <= '0;
        r_act[i] <= 1'b0;
        r_par[i] <= '0;
        r_br[i]  <= 1'b0;
      end
      for (int unsigned i = 0; i < NNODE; i++) r_node[i] <= '0;
      for (int unsigned i = 0; i < NSYM; i++)  r_leaf[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          for (int unsigned i = 0; i < NPOOL; i++) begin
            r_w[i]   <= (i < NSYM) ? w_freq[i] : '0;
            r_act[i] <= (i < NSYM);
            r_par[i] <= '0;
            r_br[i]  <= 1'b0;
          end
          r_sat   <= 1'b0;
          r_k     <= 3'd1;
          r_idx   <= '0;
          r_state <= S_SCAN1;
        end
        S_SCAN1: begin
          if (w_take1) begin
            r_found <= 1'b1;
            r_best  <= r_w[r_idx];
            r_min1  <= r_idx;
          end else if (w_first) begin
            r_found <= 1'b0;
          end
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= S_SCAN2;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        S_SCAN2: begin
          if (w_take2) begin
            r_found <= 1'b1;
            r_best  <= r_w[r_idx];
            r_min2  <= r_idx;
          end else if (w_first) begin
            r_found <= 1'b0;
          end
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= S_MERGE;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        S_MERGE: begin
          r_w[w_new]    <= w_merged;
          r_act[w_new]  <= 1'b1;
          r_act[r_min1] <= 1'b0;
          r_act[r_min2] <= 1'b0;
          r_par[r_min1] <= {1'b0, r_k};
          r_par[r_min2] <= {1'b0, r_k};
          r_br[r_min1]  <= 1'b0;
          r_br[r_min2]  <= 1'b1;
          if (w_sum[WW]) r_sat <= 1'b1;
          if (r_k == LAST_K) begin
            r_state <= S_DONE;
          end else begin
            r_k     <= r_k + 3'd1;
            r_state <= S_SCAN1;
          end
        end
        S_DONE: begin
          for (int unsigned i = 0; i < NNODE - 1; i++)
            r_node[i] <= {r_par[NSYM+i], r_br[NSYM+i], r_w[NSYM+i]};
          // Last node is always the root
          r_node[NNODE-1] <= {4'hF, 1'b1, r_w[NPOOL-1]};
          for (int unsigned i = 0; i < NSYM; i++)
            r_leaf[i] <= {r_par[i], r_br[i]};
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sat  = r_sat;

  assign info_node_1 = r_node[0];
  assign info_node_2 = r_node[1];
  assign info_node_3 = r_node[2];
  assign info_node_4 = r_node[3];
  assign info_node_5 = r_node[4];
  assign info_node_6 = r_node[5];
  assign info_node_7 = r_node[6];

  assign leaf_info_0 = r_leaf[0];
  assign leaf_info_1 = r_leaf[1];
  assign leaf_info_2 = r_leaf[2];
  assign leaf_info_3 = r_leaf[3];
  assign leaf_info_4 = r_leaf[4];
  assign leaf_info_5 = r_leaf[5];
  assign leaf_info_6 = r_leaf[6];
  assign leaf_info_7 = r_leaf[7];

endmodule

// File: tb/tb_huffman_tree_build.sv
// tb_huffman_tree_build
//   Directed bench for huffman_tree_build: latency, tree contents for
//   distinct/tied/saturating/zero frequencies, start-while-busy and
//   mid-build reset.
module tb_huffman_tree_build;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [7:0]  freq [8];
  logic        busy, done, sat;
  logic [12:0] node_o [7];
  logic [4:0]  leaf_o [8];

  int errors = 0;
  int checks = 0;

  // Hand-derived tree for freq = 1..8
  logic [12:0] t1_node [7] = '{
    {4'd2, 1'b1, 8'd3},  {4'd4, 1'b1, 8'd6},  {4'd6, 1'b0, 8'd9},
    {4'd6, 1'b1, 8'd12}, {4'd7, 1'b0, 8'd15}, {4'd7, 1'b1, 8'd21},
    {4'hF, 1'b1, 8'd36}};
  logic [4:0] t1_leaf [8] = '{5'b00010, 5'b00011, 5'b00100, 5'b00110,
                              5'b00111, 5'b01000, 5'b01010, 5'b01011};

  // Balanced shape produced when all weights tie
  logic [3:0] bal_par  [7] = '{4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd7, 4'hF};
  logic       bal_br   [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [4:0] bal_leaf [8] = '{5'b00010, 5'b00011, 5'b00100, 5'b00101,
                               5'b00110, 5'b00111, 5'b01000, 5'b01001};

  huffman_tree_build dut (
    .CLK(CLK), .RST(RST), .start(start),
    .freq_0(freq[0]), .freq_1(freq[1]), .freq_2(freq[2]), .freq_3(freq[3]),
    .freq_4(freq[4]), .freq_5(freq[5]), .freq_6(freq[6]), .freq_7(freq[7]),
    .busy(busy), .done(done), .sat(sat),
    .info_node_1(node_o[0]), .info_node_2(node_o[1]), .info_node_3(node_o[2]),
    .info_node_4(node_o[3]), .info_node_5(node_o[4]), .info_node_6(node_o[5]),
    .info_node_7(node_o[6]),
    .leaf_info_0(leaf_o[0]), .leaf_info_1(leaf_o[1]), .leaf_info_2(leaf_o[2]),
    .leaf_info_3(leaf_o[3]), .leaf_info_4(leaf_o[4]), .leaf_info_5(leaf_o[5]),
    .leaf_info_6(leaf_o[6]), .leaf_info_7(leaf_o[7])
  );

  always #5 CLK = ~CLK;

  task automatic set_freq(input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < 8; i++) freq[i] = base + 8'(i) * step;
  endtask

  // Drive start across one rising edge; returns 1 time unit after that edge
  task automatic kick();
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  // Wait for done, counting edges after the start edge; optional stray start
  task automatic wait_done(input int stray_at, output int lat);
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge CLK);
      #1;
      if (stray_at != 0 && n == stray_at)     start = 1'b1;
      if (stray_at != 0 && n == stray_at + 1) start = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    start = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if ({busy, done, sat} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=000", {busy, done, sat});
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (node_o[k] !== 13'd0) begin
        errors++;
        $display("FAIL reset_node%0d got=%h want=0", k + 1, node_o[k]);
      end
    end
    for (int s = 0; s < 8; s++) begin
      checks++;
      if (leaf_o[s] !== 5'd0) begin
        errors++;
        $display("FAIL reset_leaf%0d got=%h want=0", s, leaf_o[s]);
      end
    end
  endtask

  task automatic test_distinct();
    int lat;
    set_freq(8'd1, 8'd1);
    kick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL distinct_busy_load got=%b want=1", busy);
    end
    wait_done(0, lat);
    checks++;
    if (lat !== 219) begin
      errors++;
      $display("FAIL distinct_latency got=%0d want=219", lat);
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (node_o[k] !== t1_node[k]) begin
        errors++;
        $display("FAIL distinct_node%0d got=%h want=%h", k + 1, node_o[k], t1_node[k]);
      end
    end
    for (int s = 0; s < 8; s++) begin
      checks++;
      if (leaf_o[s] !== t1_leaf[s]) begin
        errors++;
        $display("FAIL distinct_leaf%0d got=%b want=%b", s, leaf_o[s], t1_leaf[s]);
      end
    end
    checks++;
    if ({sat, busy} !== 2'b00) begin
      errors++;
      $display("FAIL distinct_sat_busy got=%b want=00", {sat, busy});
    end
    @(posedge CLK);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL distinct_done_pulse got=%b want=0", done);
    end
  endtask

  task automatic test_ties();
    int lat;
    logic [12:0] exp_n;
    set_freq(8'd1, 8'd0);
    kick();
    wait_done(0, lat);
    checks++;
    if (lat !== 219) begin
      errors++;
      $display("FAIL ties_latency got=%0d want=219", lat);
    end
    for (int k = 0; k < 7; k++) begin
      exp_n = {bal_par[k], bal_br[k], (k < 4) ? 8'd2 : ((k < 6) ? 8'd4 : 8'd8)};
      checks++;
      if (node_o[k] !== exp_n) begin
        errors++;
        $display("FAIL ties_node%0d got=%h want=%h", k + 1, node_o[k], exp_n);
      end
    end
    for (int s = 0; s < 8; s++) begin
      checks++;
      if (leaf_o[s] !== bal_leaf[s]) begin
        errors++;
        $display("FAIL ties_leaf%0d got=%b want=%b", s, leaf_o[s], bal_leaf[s]);
      end
    end
  endtask

  task automatic test_saturate();
    int lat;
    logic [12:0] exp_n;
    set_freq(8'd100, 8'd0);
    kick();
    wait_done(0, lat);
    checks++;
    if (lat !== 219) begin
      errors++;
      $display("FAIL sat_latency got=%0d want=219", lat);
    end
    checks++;
    if (sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_flag got=%b want=1", sat);
    end
    for (int k = 0; k < 7; k++) begin
      exp_n = {bal_par[k], bal_br[k], (k < 4) ? 8'd200 : 8'hFF};
      checks++;
      if (node_o[k] !== exp_n) begin
        errors++;
        $display("FAIL sat_node%0d got=%h want=%h", k + 1, node_o[k], exp_n);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    int extra;
    set_freq(8'd1, 8'd1);
    kick();
    wait_done(50, lat);
    checks++;
    if (lat !== 219) begin
      errors++;
      $display("FAIL busy_start_latency got=%0d want=219", lat);
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (node_o[k] !== t1_node[k]) begin
        errors++;
        $display("FAIL busy_start_node%0d got=%h want=%h", k + 1, node_o[k], t1_node[k]);
      end
    end
    for (int s = 0; s < 8; s++) begin
      checks++;
      if (leaf_o[s] !== t1_leaf[s]) begin
        errors++;
        $display("FAIL busy_start_leaf%0d got=%b want=%b", s, leaf_o[s], t1_leaf[s]);
      end
    end
    checks++;
    if (sat !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_sat got=%b want=0", sat);
    end
    extra = 0;
    for (int n = 0; n < 240; n++) begin
      @(posedge CLK);
      #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_start_rebuild got=%0d active cycles want=0", extra);
    end
  endtask

  task automatic test_reset_mid_build();
    int lat;
    int dones;
    set_freq(8'd1, 8'd0);
    kick();
    for (int n = 1; n <= 100; n++) begin
      @(posedge CLK);
      #1;
    end
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    checks++;
    if ({busy, done, sat} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_flags got=%b want=000", {busy, done, sat});
    end
    checks++;
    if (node_o[6] !== 13'd0) begin
      errors++;
      $display("FAIL midrst_node7 got=%h want=0", node_o[6]);
    end
    checks++;
    if (leaf_o[0] !== 5'd0) begin
      errors++;
      $display("FAIL midrst_leaf0 got=%b want=0", leaf_o[0]);
    end
    dones = 0;
    for (int n = 0; n < 250; n++) begin
      @(posedge CLK);
      #1;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL midrst_done got=%0d pulses want=0", dones);
    end
    set_freq(8'd1, 8'd1);
    kick();
    wait_done(0, lat);
    checks++;
    if (lat !== 219) begin
      errors++;
      $display("FAIL midrst_latency got=%0d want=219", lat);
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (node_o[k] !== t1_node[k]) begin
        errors++;
        $display("FAIL midrst_node%0d got=%h want=%h", k + 1, node_o[k], t1_node[k]);
      end
    end
    for (int s = 0; s < 8; s++) begin
      checks++;
      if (leaf_o[s] !== t1_leaf[s]) begin
        errors++;
        $display("FAIL midrst_leaf%0d got=%b want=%b", s, leaf_o[s], t1_leaf[s]);
      end
    end
  endtask

  task automatic test_zero();
    int lat;
    logic [12:0] exp_n;
    set_freq(8'd0, 8'd0);
    kick();
    wait_done(0, lat);
    checks++;
    if (lat !== 219) begin
      errors++;
      $display("FAIL zero_latency got=%0d want=219", lat);
    end
    for (int k = 0; k < 7; k++) begin
      exp_n = {bal_par[k], bal_br[k], 8'd0};
      checks++;
      if (node_o[k] !== exp_n) begin
        errors++;
        $display("FAIL zero_node%0d got=%h want=%h", k + 1, node_o[k], exp_n);
      end
    end
    for (int s = 0; s < 8; s++) begin
      checks++;
      if (leaf_o[s] !== bal_leaf[s]) begin
        errors++;
        $display("FAIL zero_leaf%0d got=%b want=%b", s, leaf_o[s], bal_leaf[s]);
      end
    end
    checks++;
    if (sat !== 1'b0) begin
      errors++;
      $display("FAIL zero_sat got=%b want=0", sat);
    end
  endtask

  initial begin
    RST = 1'b1;
    start = 1'b0;
    set_freq(8'd0, 8'd0);
    test_reset();
    test_distinct();
    test_ties();
    test_saturate();
    test_start_while_busy();
    test_reset_mid_build();
    test_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
